// File: rtl/dfh_csr_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dfh_csr_responder_pkg
//  Description : Shared offsets, DFH layout and response record for the
//                feature CSR responder.
//                Contents:
//                  DFH_OFFSET, GUID_L_OFFSET, GUID_H_OFFSET, ACC_CNT_OFFSET
//                  DFH_TYPE_AFU  - DFH feature type for an AFU
//                  t_dfh         - Device Feature Header word layout
//                  t_csr_rsp     - response payload (write flag, error, data)
//  Revision    : 1.0 - initial release
// ============================================================================
package dfh_csr_responder_pkg;

    localparam int unsigned DFH_OFFSET     = 32'h00;
    localparam int unsigned GUID_L_OFFSET  = 32'h08;
    localparam int unsigned GUID_H_OFFSET  = 32'h10;
    localparam int unsigned ACC_CNT_OFFSET = 32'h20;

    localparam logic [3:0] DFH_TYPE_AFU = 4'h1;

    typedef struct packed {
        logic [3:0]  feature_type;
        logic [18:0] rsvd;
        logic        eol;
        logic [23:0] next;
        logic [3:0]  rev;
        logic [11:0] id;
    } t_dfh;

    // Tag is carried beside this record because its width is a parameter.
    typedef struct packed {
        logic        write;
        logic        err;
        logic [63:0] rdata;
    } t_csr_rsp;

endpackage
`default_nettype wire

// File: rtl/dfh_csr_rsp_reg.sv
`default_nettype none
// ============================================================================
//  Module      : dfh_csr_rsp_reg
//  Description : Single-entry response holding register with request/response
//                valid/ready handshake. A new request may be accepted in the
//                same cycle the held response is consumed.
//  Ports       : clk, rst_n (sync, active-low)
//                i_req_valid / o_req_ready / o_accept : request side
//                i_rsp, i_tag                         : response to capture
//                o_rsp_valid / i_rsp_ready            : response handshake
//                o_rsp, o_tag                         : held response
//  Revision    : 1.0 - initial release
// ============================================================================
module dfh_csr_rsp_reg
    import dfh_csr_responder_pkg::*;
#(
    parameter int unsigned TAG_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    output logic             o_accept,
    input  t_csr_rsp         i_rsp,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output t_csr_rsp         o_rsp,
    output logic [TAG_W-1:0] o_tag
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic             w_req_ready;
    logic             w_accept;
    t_csr_rsp         r_rsp;
    logic [TAG_W-1:0] r_tag;

    always_comb begin
        w_req_ready = (r_state == ST_IDLE) || i_rsp_ready;
        w_accept    = i_req_valid && w_req_ready;
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_RESP;
            ST_RESP: if (i_rsp_ready && !w_accept) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_rsp   <= '0;
            r_tag   <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Fields only change on acceptance, so they stay stable under backpressure.
            if (w_accept) begin
                r_rsp <= i_rsp;
                r_tag <= i_tag;
            end
        end
    end

    assign o_req_ready = w_req_ready;
    assign o_accept    = w_accept;
    assign o_rsp_valid = (r_state == ST_RESP);
    assign o_rsp       = r_rsp;
    assign o_tag       = r_tag;

endmodule
`default_nettype wire

// File: rtl/dfh_csr_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dfh_csr_responder
//  Description : Feature CSR responder for one accelerator function. Serves
//                DFH (0x00), GUID_L (0x08), GUID_H (0x10) and a byte-writable
//                scratch register at SCRATCH_ADDR. One response per request,
//                returned the cycle after acceptance.
//  Ports       : clk, rst_n (sync, active-low)
//                req_valid/req_ready/req_write/req_addr/req_wdata/req_wstrb/
//                req_tag : request channel
//                rsp_valid/rsp_ready/rsp_write/rsp_rdata/rsp_tag/rsp_err :
//                response channel (rsp_err flags a misaligned address)
//  Options     : DFH_CSR_ACCESS_CNT_EN - adds a 32-bit access counter at 0x20
//  Revision    : 1.0 - initial release
// ============================================================================
module dfh_csr_responder
    import dfh_csr_responder_pkg::*;
#(
    parameter int unsigned        ADDR_W         = 12,
    parameter int unsigned        TAG_W          = 10,
    parameter logic [127:0]       FEATURE_GUID   = 128'h0,
    parameter logic [ADDR_W-1:0]  SCRATCH_ADDR   = 'h100,
    parameter logic [11:0]        DFH_FEATURE_ID = 12'h0,
    parameter logic [3:0]         DFH_REV        = 4'h0,
    parameter logic [23:0]        DFH_NEXT       = 24'h0,
    parameter logic               DFH_EOL        = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    input  logic [7:0]        req_wstrb,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [63:0]       rsp_rdata,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_err
);

    // Scratch must be 8-aligned and clear of the fixed 0x00-0x20 window.
    if ((SCRATCH_ADDR[2:0] != 3'b000) ||
        (SCRATCH_ADDR <= ADDR_W'(ACC_CNT_OFFSET))) begin : g_bad_scratch_addr
        $error("dfh_csr_responder: SCRATCH_ADDR must be 8-aligned and above 0x20");
    end

    localparam t_dfh c_dfh = '{
        feature_type: DFH_TYPE_AFU,
        rsvd:         19'h0,
        eol:          DFH_EOL,
        next:         DFH_NEXT,
        rev:          DFH_REV,
        id:           DFH_FEATURE_ID
    };

    logic        w_accept;
    logic        w_aligned;
    logic        w_hit_scratch;
    logic [63:0] w_rd_data;
    logic [63:0] r_scratch;
    t_csr_rsp    w_rsp_nxt;
    t_csr_rsp    w_rsp_q;

`ifdef DFH_CSR_ACCESS_CNT_EN
    logic [31:0] r_acc_cnt;
    logic        w_hit_cnt;
    assign w_hit_cnt = w_aligned && (req_addr == ADDR_W'(ACC_CNT_OFFSET));
`endif

    assign w_aligned     = (req_addr[2:0] == 3'b000);
    assign w_hit_scratch = w_aligned && (req_addr == SCRATCH_ADDR);

    always_comb begin
        w_rd_data = '0;
        if (w_aligned) begin
            if (req_addr == ADDR_W'(DFH_OFFSET))          w_rd_data = c_dfh;
            else if (req_addr == ADDR_W'(GUID_L_OFFSET))  w_rd_data = FEATURE_GUID[63:0];
            else if (req_addr == ADDR_W'(GUID_H_OFFSET))  w_rd_data = FEATURE_GUID[127:64];
            else if (w_hit_scratch)                       w_rd_data = r_scratch;
`ifdef DFH_CSR_ACCESS_CNT_EN
            // The read itself is counted, so report the post-increment value.
            else if (w_hit_cnt)                           w_rd_data = {32'h0, r_acc_cnt + 32'd1};
`endif
        end
    end

    always_comb begin
        w_rsp_nxt       = '0;
        w_rsp_nxt.write = req_write;
        w_rsp_nxt.err   = !w_aligned;
        w_rsp_nxt.rdata = req_write ? 64'h0 : w_rd_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_scratch <= '0;
        end else if (w_accept && req_write && w_hit_scratch) begin
            for (int i = 0; i < 8; i++) begin
                if (req_wstrb[i]) r_scratch[i*8 +: 8] <= req_wdata[i*8 +: 8];
            end
        end
    end

`ifdef DFH_CSR_ACCESS_CNT_EN
    // Misaligned requests change no state, so they are not counted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc_cnt <= '0;
        end else if (w_accept && w_aligned) begin
            if (req_write && w_hit_cnt) r_acc_cnt <= '0;
            else                        r_acc_cnt <= r_acc_cnt + 32'd1;
        end
    end
`endif

    dfh_csr_rsp_reg #(
        .TAG_W (TAG_W)
    ) u_rsp_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .o_accept    (w_accept),
        .i_rsp       (w_rsp_nxt),
        .i_tag       (req_tag),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp       (w_rsp_q),
        .o_tag       (rsp_tag)
    );

    assign rsp_write = w_rsp_q.write;
    assign rsp_err   = w_rsp_q.err;
    assign rsp_rdata = w_rsp_q.rdata;

endmodule
`default_nettype wire

// File: tb/tb_dfh_csr_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dfh_csr_responder
//  Description : Self-checking bench for dfh_csr_responder: a register-map
//                model predicts every response, and directed sequences pin
//                literal values (GUIDs, scratch merges, backpressure, reset).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dfh_csr_responder;

    localparam int unsigned       ADDR_W = 12;
    localparam int unsigned       TAG_W  = 10;
    localparam logic [127:0]      GUID   = 128'h56E203E9864F49A7B94B12284C31E02B;
    localparam logic [ADDR_W-1:0] SCR    = 12'h100;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [63:0]       req_wdata = '0;
    logic [7:0]        req_wstrb = '0;
    logic [TAG_W-1:0]  req_tag = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic              rsp_write;
    logic [63:0]       rsp_rdata;
    logic [TAG_W-1:0]  rsp_tag;
    logic              rsp_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dfh_csr_responder #(
        .ADDR_W       (ADDR_W),
        .TAG_W        (TAG_W),
        .FEATURE_GUID (GUID),
        .SCRATCH_ADDR (SCR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_tag   (rsp_tag),
        .rsp_err   (rsp_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- register-map model ----------------
    logic             m_init = 1'b0;
    logic             m_valid = 1'b0;
    logic             m_write = 1'b0;
    logic             m_err = 1'b0;
    logic [63:0]      m_rdata = '0;
    logic [TAG_W-1:0] m_tag = '0;
    logic [7:0]       m_bytes [8];
    logic [31:0]      m_cnt = '0;
    logic             m_acc;

    assign m_acc = req_valid && (!m_valid || rsp_ready);

    function automatic logic [63:0] model_read(input logic [ADDR_W-1:0] a);
        logic [63:0] s;
        for (int i = 0; i < 8; i++) s[i*8 +: 8] = m_bytes[i];
        if (a == 12'h000) return {4'h1, 19'h0, 1'b1, 24'h0, 4'h0, 12'h0};
        if (a == 12'h008) return GUID[63:0];
        if (a == 12'h010) return GUID[127:64];
        if (a == SCR)     return s;
`ifdef DFH_CSR_ACCESS_CNT_EN
        if (a == 12'h020) return {32'h0, m_cnt + 32'd1};
`endif
        return 64'h0;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_init  <= 1'b1;
            m_valid <= 1'b0;
            m_cnt   <= '0;
            for (int i = 0; i < 8; i++) m_bytes[i] <= 8'h0;
        end else if (m_acc) begin
            m_valid <= 1'b1;
            m_write <= req_write;
            m_tag   <= req_tag;
            if (req_addr[2:0] != 3'b000) begin
                m_err   <= 1'b1;
                m_rdata <= 64'h0;
            end else begin
                m_err   <= 1'b0;
                m_rdata <= req_write ? 64'h0 : model_read(req_addr);
                if (req_write && req_addr == SCR)
                    for (int i = 0; i < 8; i++)
                        if (req_wstrb[i]) m_bytes[i] <= req_wdata[i*8 +: 8];
                if (req_write && req_addr == 12'h020) m_cnt <= '0;
                else                                  m_cnt <= m_cnt + 32'd1;
            end
        end else if (rsp_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Cycle-by-cycle compare against the model.
    always @(negedge clk) begin
        if (m_init && rst_n) begin
            chk("req_ready", {63'h0, req_ready}, {63'h0, (!m_valid || rsp_ready)});
            chk("rsp_valid", {63'h0, rsp_valid}, {63'h0, m_valid});
            if (m_valid) begin
                chk("rsp_write", {63'h0, rsp_write}, {63'h0, m_write});
                chk("rsp_err",   {63'h0, rsp_err},   {63'h0, m_err});
                chk("rsp_rdata", rsp_rdata, m_rdata);
                chk("rsp_tag",   64'(rsp_tag), 64'(m_tag));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    // Entered at posedge+1; returns at posedge+1 just after the acceptance edge.
    task automatic issue(input logic w, input logic [ADDR_W-1:0] a, input logic [63:0] d,
                         input logic [7:0] s, input logic [TAG_W-1:0] t);
        int k;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s; req_tag = t;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: req_ready stuck at 0, required 1");
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic expect_rsp(input string name, input logic [63:0] d, input logic e,
                              input logic [TAG_W-1:0] t);
        @(negedge clk);
        chk({name, "_valid"}, {63'h0, rsp_valid}, 64'h1);
        chk({name, "_data"},  rsp_rdata, d);
        chk({name, "_err"},   {63'h0, rsp_err}, {63'h0, e});
        chk({name, "_tag"},   64'(rsp_tag), 64'(t));
        @(posedge clk); #1;
    endtask

    task automatic rd(input string name, input logic [ADDR_W-1:0] a, input logic [TAG_W-1:0] t,
                      input logic [63:0] d, input logic e);
        issue(1'b0, a, 64'h0, 8'h00, t);
        expect_rsp(name, d, e, t);
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [63:0] d, input logic [7:0] s,
                      input logic [TAG_W-1:0] t);
        issue(1'b1, a, d, s, t);
        expect_rsp("wr", 64'h0, a[2:0] != 3'b000, t);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        n_vec++; n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        do_reset();
        @(negedge clk);
        chk("rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        chk("rst_req_ready", {63'h0, req_ready}, 64'h1);
        chk("rst_rsp_rdata", rsp_rdata, 64'h0);
        chk("rst_rsp_tag",   64'(rsp_tag), 64'h0);
        chk("rst_rsp_err",   {63'h0, rsp_err}, 64'h0);
        chk("rst_rsp_write", {63'h0, rsp_write}, 64'h0);
        @(posedge clk); #1;

        // DFH and GUID readback
        rd("dfh",    12'h000, 10'h001, 64'h1000_0100_0000_0000, 1'b0);
        rd("guid_l", 12'h008, 10'h2A5, 64'hB94B12284C31E02B, 1'b0);
        rd("guid_h", 12'h010, 10'h3FF, 64'h56E203E9864F49A7, 1'b0);

        // Scratch byte-wise writes
        rd("scr_init", SCR, 10'h004, 64'h0, 1'b0);
        wr(SCR, 64'hDEADBEEF_CAFEF00D, 8'hFF, 10'h005);
        wr(SCR, 64'h0, 8'h0F, 10'h006);
        rd("scr_merge", SCR, 10'h007, 64'hDEADBEEF_00000000, 1'b0);
        wr(SCR, 64'h1111_2222_3333_4444, 8'h00, 10'h008);
        rd("scr_nostrb", SCR, 10'h009, 64'hDEADBEEF_00000000, 1'b0);

        // Errors and dropped/unmapped accesses
        rd("misalign", 12'h00C, 10'h00A, 64'h0, 1'b1);
        wr(12'h008, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 10'h00B);
        rd("guid_ro", 12'h008, 10'h00C, 64'hB94B12284C31E02B, 1'b0);
        rd("unmapped", 12'h200, 10'h00D, 64'h0, 1'b0);
        wr(SCR + 12'h004, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 10'h00E);
        rd("scr_after_misalign", SCR, 10'h00F, 64'hDEADBEEF_00000000, 1'b0);

        // Back-to-back write then read of scratch
        req_valid = 1'b1; req_write = 1'b1; req_addr = SCR;
        req_wdata = 64'h0123_4567_89AB_CDEF; req_wstrb = 8'hFF; req_tag = 10'h010;
        @(posedge clk); #1;
        req_write = 1'b0; req_wdata = 64'h0; req_wstrb = 8'h00; req_tag = 10'h011;
        @(negedge clk);
        chk("b2b_wr_valid", {63'h0, rsp_valid}, 64'h1);
        chk("b2b_wr_write", {63'h0, rsp_write}, 64'h1);
        chk("b2b_rd_ready", {63'h0, req_ready}, 64'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_rd_data", rsp_rdata, 64'h0123_4567_89AB_CDEF);
        chk("b2b_rd_tag",  64'(rsp_tag), 64'h011);
        @(posedge clk); #1;

        // Backpressure with a second request waiting
        rsp_ready = 1'b0;
        issue(1'b0, 12'h008, 64'h0, 8'h00, 10'h021);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h010; req_tag = 10'h022;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_req_ready", {63'h0, req_ready}, 64'h0);
            chk("bp_rdata", rsp_rdata, 64'hB94B12284C31E02B);
            chk("bp_tag", 64'(rsp_tag), 64'h021);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", {63'h0, req_ready}, 64'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("bp_second_data", rsp_rdata, 64'h56E203E9864F49A7);
        chk("bp_second_tag",  64'(rsp_tag), 64'h022);
        @(posedge clk); #1;

        // Reset while a response is pending
        rsp_ready = 1'b0;
        issue(1'b1, SCR, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, 10'h030);
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_valid", {63'h0, rsp_valid}, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        rd("rst_mid_scratch", SCR, 10'h031, 64'h0, 1'b0);

        // Access counter at 0x20
        do_reset();
        rd("cnt_a1", 12'h008, 10'h040, 64'hB94B12284C31E02B, 1'b0);
        rd("cnt_a2", 12'h010, 10'h041, 64'h56E203E9864F49A7, 1'b0);
        rd("cnt_a3", 12'h000, 10'h042, 64'h1000_0100_0000_0000, 1'b0);
`ifdef DFH_CSR_ACCESS_CNT_EN
        rd("cnt_read", 12'h020, 10'h043, 64'h4, 1'b0);
        wr(12'h020, 64'h0, 8'hFF, 10'h044);
        rd("cnt_clear", 12'h020, 10'h045, 64'h1, 1'b0);
`else
        rd("cnt_absent", 12'h020, 10'h043, 64'h0, 1'b0);
        wr(12'h020, 64'hFF, 8'hFF, 10'h044);
        rd("cnt_absent2", 12'h020, 10'h045, 64'h0, 1'b0);
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dfh_csr_responder.md
# dfh_csr_responder

Feature CSR responder answering host MMIO requests for one accelerator function. Serves the Device Feature Header (DFH) at 0x00, GUID_L at 0x08, GUID_H at 0x10, and a read/write scratch register at a parameterized offset. It sits behind the PF/VF MMIO demux as the terminal CSR target that PF/VF access tests probe: they read the GUIDs and write/read the scratch register.

## Interface
- `ADDR_W`, 12: request byte-address width.
- `TAG_W`, 10: request tag width, echoed on the response.
- `FEATURE_GUID`, 128'h0: GUID returned at 0x08 (low) and 0x10 (high).
- `SCRATCH_ADDR`, 'h100: byte offset of the scratch register; 8-aligned, not in 0x00–0x20.
- `DFH_FEATURE_ID`, 12'h0: DFH[11:0].
- `DFH_REV`, 4'h0: DFH[15:12].
- `DFH_NEXT`, 24'h0: DFH[39:16], next-DFH offset.
- `DFH_EOL`, 1'b1: DFH[40].
- `clk` in 1: sole clock.
- `rst_n` in 1: reset; synchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder accepts the request this cycle.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 64: write data.
- `req_wstrb` in 8: byte enables for writes.
- `req_tag` in TAG_W: request tag.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_write` out 1: response belongs to a write.
- `rsp_rdata` out 64: read data; 0 for writes.
- `rsp_tag` out TAG_W: echoed tag.
- `rsp_err` out 1: misaligned access.

## Operation
- FSM states IDLE and RESP.
  - IDLE: `req_ready`=1. Request accepted → RESP.
  - RESP: `rsp_valid`=1 and response fields held stable.
    - `rsp_ready`=1 with a new request: accepted the same cycle; stay in RESP.
    - `rsp_ready`=1 with no request: → IDLE.
    - `rsp_ready`=0: `req_ready`=0.
- `req_ready` = (state==IDLE) || `rsp_ready`.
- Decode uses `req_addr` with bits [2:0] required to be zero.
  - Misaligned access: `rsp_err`=1, `rsp_rdata`=0, no state change.
- Read map:
  - 0x00: DFH = {4'h1, 19'h0, EOL, NEXT, REV, ID}.
  - 0x08: GUID[63:0].
  - 0x10: GUID[127:64].
  - SCRATCH_ADDR: scratch value.
  - Unmapped offsets return 0 with `rsp_err`=0.
- Writes:
  - Scratch updates byte-wise per `req_wstrb`; the update is visible to the next accepted read.
  - Writes to read-only or unmapped offsets are dropped with `rsp_err`=0.
  - `req_wstrb`=0 leaves scratch unchanged; the response is still returned.
- Responses are strictly in request order (single outstanding response).

## Timing
- Reset values: state IDLE, `rsp_valid`=0, `rsp_write`=0, `rsp_rdata`=0, `rsp_tag`=0, `rsp_err`=0, scratch=0, `req_ready`=1 on the first cycle after reset.
- Latency: a request accepted in cycle N produces the response in cycle N+1.
- Sustained throughput: one access per cycle when `rsp_ready` stays high.
- Reset asserted mid-transaction drops the pending response without handshake. Scratch returns to 0.
- Write followed immediately by a read of scratch: the read returns the new value.

## Configuration
- `DFH_CSR_ACCESS_CNT_EN` defined: adds a 32-bit access counter, read at 0x20 zero-extended to 64 bits.
  - Increments on every accepted request, including its own reads.
  - Wraps 0xFFFF_FFFF → 0.
  - Any aligned write to 0x20 clears it to 0; the clear wins over the same-cycle increment.
- Macro undefined: 0x20 is unmapped (reads 0, writes dropped) and the counter logic is absent.

## Structure
- Package `dfh_csr_responder_pkg` holds:
  - Offsets `DFH_OFFSET`, `GUID_L_OFFSET`, `GUID_H_OFFSET`, `ACC_CNT_OFFSET`, and `DFH_TYPE_AFU`=4'h1.
  - `t_dfh` packed struct with fields type/rsvd/eol/next/rev/id.
  - `t_csr_rsp` packed struct holding the response fields.
- One sub-module, `dfh_csr_rsp_reg`: the single-entry response holding register with the valid/ready logic. Decode and scratch stay in the top.
- An elaboration-time assertion rejects an unaligned `SCRATCH_ADDR` or one in 0x00–0x20.

## Test plan
- GUID readback: with FEATURE_GUID=128'h56E203E9864F49A7B94B12284C31E02B, read 0x08 → 64'hB94B12284C31E02B; read 0x10 → 64'h56E203E9864F49A7; `rsp_err`=0; tags echoed.
- Scratch write/read: write 0x100 with 64'hDEADBEEF_CAFEF00D, wstrb 0xFF. Then write 64'h0, wstrb 0x0F. Read 0x100 → 64'hDEADBEEF_00000000.
- Back-to-back: write then read of scratch issued on consecutive cycles with `rsp_ready`=1 → responses in cycles N+1 and N+2; the read returns the written data.
- Backpressure: hold `rsp_ready`=0 for 5 cycles with a second request waiting → `req_ready`=0 and the response stays stable. Release → second request accepted that cycle.
- Errors: read 0x0C → `rsp_err`=1, rdata 0. Write to 0x08 → GUID unchanged. Read 0x200 → 0, `rsp_err`=0.
- Reset mid-response: `rst_n`=0 while `rsp_valid`=1 → next cycle `rsp_valid`=0 and scratch=0. With `DFH_CSR_ACCESS_CNT_EN`: after 3 accesses, a read of 0x20 returns 4; a write to 0x20 then a read returns 1.
